// File: rtl/cg_iteration_sequencer.sv
// cg_iteration_sequencer: conjugate-gradient iteration control FSM.
// Define CG_TOLERANCE_CHECK_EN to enable early exit on the residual tolerance.
module cg_iteration_sequencer #(
  parameter int element_width = 32,
  parameter int no_of_units = 8,
  parameter int number_of_equations_per_cluster = 10,
  parameter int iter_width = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [iter_width-1:0]    max_iter,
  input  logic [element_width-1:0] tolerance,
  output logic                     vxv_go,
  input  logic                     vxv_done,
  input  logic [element_width-1:0] vxv_result,
  output logic                     mxv_go,
  input  logic                     mxv_done,
  output logic                     div_go,
  output logic [element_width-1:0] div_num,
  output logic [element_width-1:0] div_den,
  input  logic                     div_done,
  input  logic [element_width-1:0] div_result,
  output logic                     upd_go,
  output logic [1:0]               upd_sel,
  output logic [element_width-1:0] upd_coef,
  input  logic                     upd_done,
  output logic                     chunk_read,
  output logic [31:0]              chunk_index,
  output logic                     busy,
  output logic                     converged,
  output logic                     done_all,
  output logic [iter_width-1:0]    iter_count
);
  localparam int unsigned chunks =
    (number_of_equations_per_cluster + no_of_units - 1)
    / no_of_units;
  localparam logic [31:0] span = 32'(2 * chunks);

  typedef enum logic [3:0] {
    IDLE, RSOLD, AP, PAP, ALPHA, UPD_X,
    UPD_R, RSNEW, CHECK, BETA, UPD_P, DONE
  } state_t;

  state_t state_q, state_d;
  logic fresh_q;
  logic [31:0] tick_q;
  logic [element_width-1:0] rsold_q, pap_q, rsnew_q;
  logic [element_width-1:0] alpha_q, beta_q;
  logic [iter_width-1:0] iter_q, iter_inc;
  logic conv_q;
  logic tol_met;
  logic vxv_phase;

`ifdef CG_TOLERANCE_CHECK_EN
  assign tol_met = (rsnew_q <= tolerance);
`else
  logic unused_tolerance;
  assign unused_tolerance = ^tolerance;
  assign tol_met = 1'b0;
`endif

  assign iter_inc = iter_q + iter_width'(1);

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:
          if (start)
            state_d = (max_iter == '0) ? DONE : RSOLD;
        RSOLD: if (vxv_done) state_d = AP;
        AP:    if (mxv_done) state_d = PAP;
        PAP:   if (vxv_done) state_d = ALPHA;
        ALPHA: if (div_done) state_d = UPD_X;
        UPD_X: if (upd_done) state_d = UPD_R;
        UPD_R: if (upd_done) state_d = RSNEW;
        RSNEW: if (vxv_done) state_d = CHECK;
        CHECK: begin
          if (tol_met || iter_inc == max_iter)
            state_d = DONE;
          else
            state_d = BETA;
        end
        BETA:  if (div_done) state_d = UPD_P;
        UPD_P: if (upd_done) state_d = AP;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // fresh_q marks the first cycle of a state; tick_q paces chunk reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fresh_q <= 1'b0;
      tick_q  <= '0;
      rsold_q <= '0;
      pap_q   <= '0;
      rsnew_q <= '0;
      alpha_q <= '0;
      beta_q  <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= (state_d != state_q);
      if (state_d != state_q)
        tick_q <= '0;
      else if (tick_q < span)
        tick_q <= tick_q + 32'd1;
      if (!abort) begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              iter_q <= '0;
              conv_q <= 1'b0;
            end
          end
          RSOLD: if (vxv_done) rsold_q <= vxv_result;
          PAP:   if (vxv_done) pap_q <= vxv_result;
          RSNEW: if (vxv_done) rsnew_q <= vxv_result;
          ALPHA: if (div_done) alpha_q <= div_result;
          BETA: begin
            if (div_done) begin
              beta_q  <= div_result;
              rsold_q <= rsnew_q;
            end
          end
          CHECK: begin
            iter_q <= iter_inc;
            conv_q <= tol_met;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    vxv_go   = 1'b0;
    mxv_go   = 1'b0;
    div_go   = 1'b0;
    upd_go   = 1'b0;
    div_num  = '0;
    div_den  = '0;
    upd_sel  = 2'd0;
    upd_coef = '0;
    unique case (state_q)
      RSOLD, PAP, RSNEW: vxv_go = fresh_q;
      AP: mxv_go = fresh_q;
      ALPHA: begin
        div_go  = fresh_q;
        div_num = rsold_q;
        div_den = pap_q;
      end
      BETA: begin
        div_go  = fresh_q;
        div_num = rsnew_q;
        div_den = rsold_q;
      end
      UPD_X: begin
        upd_go   = fresh_q;
        upd_coef = alpha_q;
      end
      UPD_R: begin
        upd_go   = fresh_q;
        upd_sel  = 2'd1;
        upd_coef = alpha_q;
      end
      UPD_P: begin
        upd_go   = fresh_q;
        upd_sel  = 2'd2;
        upd_coef = beta_q;
      end
      default: ;
    endcase
  end

  assign vxv_phase = (state_q == RSOLD) ||
                     (state_q == PAP) ||
                     (state_q == RSNEW);
  assign chunk_read = vxv_phase && tick_q[0] &&
                      (tick_q < span);
  assign chunk_index = (vxv_phase && tick_q != '0)
                     ? ((tick_q - 32'd1) >> 1) : '0;

  assign busy       = (state_q != IDLE);
  assign done_all   = (state_q == DONE);
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// tb_cg_iteration_sequencer: random unit responders plus a scoreboard
// fed by a transaction-level model of the CG solve sequence.
`timescale 1ns/1ps
module tb_cg_iteration_sequencer;
  localparam int EW = 32;
  localparam int NU = 8;
  localparam int NEQ = 10;
  localparam int IW = 16;
  localparam int C = (NEQ + NU - 1) / NU;
`ifdef CG_TOLERANCE_CHECK_EN
  localparam bit EN_TOL = 1'b1;
`else
  localparam bit EN_TOL = 1'b0;
`endif
  localparam logic [2:0] K_VXV = 3'd0;
  localparam logic [2:0] K_MXV = 3'd1;
  localparam logic [2:0] K_DIV = 3'd2;
  localparam logic [2:0] K_UPD = 3'd3;
  localparam logic [2:0] K_DONE = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [IW-1:0] max_iter = '0;
  logic [EW-1:0] tolerance = '0;
  logic vxv_go, mxv_go, div_go, upd_go;
  logic vxv_done = 1'b0;
  logic mxv_done = 1'b0;
  logic div_done = 1'b0;
  logic upd_done = 1'b0;
  logic [EW-1:0] vxv_result = '0;
  logic [EW-1:0] div_result = '0;
  logic [EW-1:0] div_num, div_den, upd_coef;
  logic [1:0] upd_sel;
  logic chunk_read, busy, converged, done_all;
  logic [31:0] chunk_index;
  logic [IW-1:0] iter_count;

  cg_iteration_sequencer #(
    .element_width(EW),
    .no_of_units(NU),
    .number_of_equations_per_cluster(NEQ),
    .iter_width(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .max_iter(max_iter), .tolerance(tolerance),
    .vxv_go(vxv_go), .vxv_done(vxv_done),
    .vxv_result(vxv_result),
    .mxv_go(mxv_go), .mxv_done(mxv_done),
    .div_go(div_go), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_result(div_result),
    .upd_go(upd_go), .upd_sel(upd_sel), .upd_coef(upd_coef),
    .upd_done(upd_done),
    .chunk_read(chunk_read), .chunk_index(chunk_index),
    .busy(busy), .converged(converged), .done_all(done_all),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t exp_q[$];
  logic [EW-1:0] vxv_vals[$];
  logic [EW-1:0] div_vals[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  bit quiet = 1'b0;
  int last_iter;
  bit last_conv;

  logic any_out;
  assign any_out = |{vxv_go, mxv_go, div_go, div_num, div_den,
                     upd_go, upd_sel, upd_coef, chunk_read,
                     chunk_index, busy, converged, done_all,
                     iter_count};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic observe(input logic [2:0] k, input logic [31:0] a,
                         input logic [31:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      check("event_data", {a, b}, {e.a, e.b});
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (vxv_go) observe(K_VXV, 32'd0, 32'd0);
      if (mxv_go) observe(K_MXV, 32'd0, 32'd0);
      if (div_go) observe(K_DIV, div_num, div_den);
      if (upd_go) observe(K_UPD, {30'd0, upd_sel}, upd_coef);
      if (done_all) begin
        done_seen++;
        observe(K_DONE, {16'd0, iter_count}, {31'd0, converged});
      end
    end
  end

  // dot-product unit: answers after all chunk reads
  initial begin
    int n;
    forever begin
      @(negedge clk);
      while (vxv_go && reset) begin
        n = 0;
        for (int k = 0; k < 2 * C + 2 && n < C; k++) begin
          @(negedge clk);
          if (chunk_read) begin
            if (!quiet) check("chunk_index", 64'(chunk_index), 64'(n));
            n++;
          end
        end
        if (!quiet) check("chunk_count", 64'(n), 64'(C));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (!quiet) begin
          vxv_result = (vxv_vals.size() != 0) ? vxv_vals.pop_front() : '0;
          vxv_done = 1'b1;
        end
        @(negedge clk);
        vxv_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      while (mxv_go && reset) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (!quiet) mxv_done = 1'b1;
        @(negedge clk);
        mxv_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      while (div_go && reset) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (!quiet) begin
          div_result = (div_vals.size() != 0) ? div_vals.pop_front() : '0;
          div_done = 1'b1;
        end
        @(negedge clk);
        div_done = 1'b0;
      end
    end
  end

  initial begin
    logic [1:0] s;
    logic [31:0] c;
    forever begin
      @(negedge clk);
      while (upd_go && reset) begin
        s = upd_sel;
        c = upd_coef;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (!quiet) check("upd_hold", {30'd0, upd_sel, upd_coef}, {30'd0, s, c});
        end
        if (!quiet) upd_done = 1'b1;
        @(negedge clk);
        upd_done = 1'b0;
      end
    end
  end

  task automatic push(input logic [2:0] k, input logic [31:0] a,
                      input logic [31:0] b);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
  endtask

  // transaction-level CG sequence for the given responder values
  task automatic model(input int m, input logic [31:0] tol,
                       input logic [31:0] vv[$], input logic [31:0] dv[$]);
    logic [31:0] rs_old, rs_new, p_ap, al, be;
    int vi = 0;
    int di = 0;
    last_iter = 0;
    last_conv = 1'b0;
    if (m == 0) begin
      push(K_DONE, 32'd0, 32'd0);
      return;
    end
    push(K_VXV, 32'd0, 32'd0);
    rs_old = vv[vi++];
    for (int it = 1; it <= m; it++) begin
      push(K_MXV, 32'd0, 32'd0);
      push(K_VXV, 32'd0, 32'd0);
      p_ap = vv[vi++];
      push(K_DIV, rs_old, p_ap);
      al = dv[di++];
      push(K_UPD, 32'd0, al);
      push(K_UPD, 32'd1, al);
      push(K_VXV, 32'd0, 32'd0);
      rs_new = vv[vi++];
      last_iter = it;
      if (EN_TOL && rs_new <= tol) begin
        last_conv = 1'b1;
        push(K_DONE, 32'(it), 32'd1);
        return;
      end
      if (it == m) begin
        push(K_DONE, 32'(it), 32'd0);
        return;
      end
      push(K_DIV, rs_new, rs_old);
      be = dv[di++];
      rs_old = rs_new;
      push(K_UPD, 32'd2, be);
    end
  endtask

  task automatic load(input int m, input logic [31:0] tol,
                      input logic [31:0] vv[$], input logic [31:0] dv[$]);
    max_iter = IW'(m);
    tolerance = tol;
    vxv_vals = vv;
    div_vals = dv;
    model(m, tol, vv, dv);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_solve(input int m, input logic [31:0] tol,
                           input logic [31:0] vv[$], input logic [31:0] dv[$]);
    int cyc = 0;
    int d0 = done_seen;
    load(m, tol, vv, dv);
    while (done_seen == d0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = busy && ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    if (done_seen == d0) begin
      checks++;
      errors++;
      $display("FAIL solve_timeout: got no done_all expected one");
    end
    repeat (3) @(negedge clk);
    check("iter_hold", 64'(iter_count), 64'(last_iter));
    check("conv_hold", 64'(converged), 64'(last_conv));
    check("busy_idle", 64'(busy), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic fill(input int m, output logic [31:0] vv[$],
                      output logic [31:0] dv[$]);
    vv.delete();
    dv.delete();
    for (int i = 0; i < 1 + 2 * m; i++)
      vv.push_back(($urandom_range(0, 3) == 0) ?
                   32'($urandom_range(0, 2000)) : $urandom);
    for (int i = 0; i < 2 * m; i++) dv.push_back($urandom);
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
    exp_q.delete();
    vxv_vals.delete();
    div_vals.delete();
    quiet = 1'b0;
  endtask

  initial begin
    logic [31:0] vv[$];
    logic [31:0] dv[$];
    int cnt;
    int d0;
    int m;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(any_out), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", 64'(any_out), 64'd0);

    fill(3, vv, dv);
    foreach (vv[i]) vv[i] = 32'h3F80_0000;
    vv[0] = 32'h4000_0000;
    run_solve(3, 32'd0, vv, dv);

    fill(4, vv, dv);
    foreach (vv[i]) vv[i] = 32'h2000_0000;
    vv[0] = 32'h3F80_0000;
    vv[1] = 32'h3F80_0000;
    run_solve(4, 32'h2834_24DC, vv, dv);

    fill(0, vv, dv);
    run_solve(0, 32'd0, vv, dv);

    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(1, 4);
      fill(m, vv, dv);
      run_solve(m, 32'($urandom_range(0, 1500)), vv, dv);
    end

    fill(5, vv, dv);
    load(5, 32'd0, vv, dv);
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 2; k++) begin
      @(negedge clk);
      if (vxv_go) cnt++;
    end
    check("reach_pap", 64'(cnt), 64'd2);
    @(negedge clk);
    d0 = done_seen;
    quiet = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_strobes",
          64'({vxv_go, mxv_go, div_go, upd_go, chunk_read}), 64'd0);
    check("abort_iter", 64'(iter_count), 64'd0);
    settle();
    check("abort_no_done", 64'(done_seen), 64'(d0));

    fill(2, vv, dv);
    run_solve(2, 32'd0, vv, dv);

    fill(3, vv, dv);
    foreach (vv[i]) vv[i] = 32'h3F80_0000;
    load(3, 32'd0, vv, dv);
    cnt = 0;
    for (int k = 0; k < 400 && cnt < 2; k++) begin
      @(negedge clk);
      if (upd_go && upd_sel == 2'd1) cnt++;
    end
    check("reach_upd_r", 64'(cnt), 64'd2);
    check("iter_before_reset", 64'(iter_count), 64'd1);
    quiet = 1'b1;
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", 64'(any_out), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    settle();

    fill(2, vv, dv);
    run_solve(2, 32'($urandom_range(0, 1500)), vv, dv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cg_iteration_sequencer.md
CG_ITERATION_SEQUENCER -- requirements
Module: cg_iteration_sequencer

Interface
REQ-001 SHALL have parameters:
- element_width, 32, scalar/float word width.
- no_of_units, 8, elements per chunk.
- number_of_equations_per_cluster, 10, vector length N.
- iter_width, 16, iteration counter width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low.
- start, in, 1, begin solve.
- abort, in, 1, synchronous return to IDLE.
- max_iter, in, iter_width, iteration limit.
- tolerance, in, element_width, residual threshold (float bits).
- vxv_go, out, 1, dot-product start pulse.
- vxv_done, in, 1, dot-product complete.
- vxv_result, in, element_width, dot-product value.
- mxv_go, out, 1, A*p start pulse.
- mxv_done, in, 1, A*p complete.
- div_go, out, 1, divider start pulse.
- div_num, out, element_width, numerator.
- div_den, out, element_width, denominator.
- div_done, in, 1, divider complete.
- div_result, in, element_width, quotient.
- upd_go, out, 1, update-unit start pulse.
- upd_sel, out, 2, update type: 0 x+a*p; 1 r-a*Ap; 2 p=r+b*p.
- upd_coef, out, element_width, alpha or beta.
- upd_done, in, 1, update complete.
- chunk_read, out, 1, chunk fetch pulse to vector memories.
- chunk_index, out, 32, current chunk number.
- busy, out, 1, solve in progress.
- converged, out, 1, tolerance met.
- done_all, out, 1, one-cycle solve-end pulse.
- iter_count, out, iter_width, completed iterations.

Function
REQ-003 SHALL implement FSM states IDLE, RSOLD, AP, PAP, ALPHA, UPD_X, UPD_R, RSNEW, CHECK, BETA, UPD_P, DONE.
REQ-004 SHALL step IDLE->RSOLD on start=1; start SHALL be ignored in every other state.
REQ-005 SHALL assert each *_go for exactly one cycle, in the first cycle of its state, then wait in that state for the matching *_done.
REQ-006 SHALL sequence RSOLD->AP->PAP->ALPHA->UPD_X->UPD_R->RSNEW->CHECK->BETA->UPD_P->AP.
REQ-007 SHALL latch vxv_result into rsold in RSOLD, into pap in PAP and into rsnew in RSNEW, on the vxv_done cycle.
REQ-008 ALPHA: div_num=rsold, div_den=pap; SHALL latch alpha=div_result on div_done.
REQ-009 BETA: div_num=rsnew, div_den=rsold; SHALL latch beta=div_result and copy rsnew into rsold on div_done.
REQ-010 upd_sel/upd_coef SHALL hold for the whole state: UPD_X 0/alpha, UPD_R 1/alpha, UPD_P 2/beta.
REQ-011 In RSOLD, PAP, RSNEW SHALL emit C=ceil(N/no_of_units) chunk_read pulses, each one cycle high followed by one cycle low, starting the cycle after vxv_go; chunk_index counts 0..C-1 and resets to 0 on state entry.
REQ-012 CHECK (one cycle): iter_count increments; if unsigned rsnew<=tolerance -> converged=1, DONE; else if new iter_count==max_iter -> DONE; else BETA.
REQ-013 max_iter=0 SHALL go IDLE->DONE directly on start, with iter_count=0.
REQ-014 DONE SHALL pulse done_all for one cycle, then return to IDLE; converged and iter_count hold until the next start.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 abort=1 in any state SHALL go to IDLE next cycle, deassert all *_go and chunk_read, and leave iter_count and converged unchanged; no done_all.
REQ-017 A *_done arriving in a state not waiting for it SHALL be ignored; a done coincident with abort SHALL lose to abort.
REQ-018 A start in IDLE SHALL clear converged and iter_count.

Reset
REQ-019 reset=0 SHALL force IDLE and drive every output 0; all internal registers (rsold, pap, rsnew, alpha, beta, counters) SHALL clear to 0 asynchronously.

Configuration
REQ-020 Macro CG_TOLERANCE_CHECK_EN defined: CHECK applies the tolerance test of REQ-012. Undefined: tolerance is ignored, converged is tied 0, and the solve always runs max_iter iterations.

Verification
REQ-021 N=10, NU=8: start; respond vxv_done after the 2nd chunk_read -> exactly 2 chunk_read pulses, chunk_index 0,1.
REQ-022 max_iter=3, tolerance=0, rsnew=0x3F800000 -> 3 full loops, done_all once, iter_count=3, converged=0.
REQ-023 EN defined, tolerance=0x283424DC, first rsnew=0x20000000 -> DONE after iteration 1, converged=1, no BETA entered.
REQ-024 rsold=0x40000000, pap=0x3F800000 -> ALPHA shows div_num=0x40000000, div_den=0x3F800000; UPD_X, UPD_R show upd_coef=div_result.
REQ-025 abort during PAP -> IDLE next cycle, busy=0, no done_all; a later start runs normally.
REQ-026 reset=0 asserted mid-UPD_R -> all outputs 0 immediately, no clock edge required.
